instr_loader: RTL and testbench



---
 rtl/cpu_pkg.sv | 20 ++
 rtl/instr_loader_if.sv | 27 ++
 rtl/byte_packer.sv | 42 ++++
 rtl/instr_loader.sv | 137 +++++++++++++
 tb/tb_instr_loader.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader FSM states and instruction-memory geometry.
package cpu_pkg;

    // Instruction-memory word-address width (same as the pc width).
    localparam int unsigned ADDR_W = 11;

    // Bytes in the image header (16-bit little-endian word count).
    localparam int unsigned HDR_BYTES = 2;

    typedef enum logic [2:0] {
        StIdle,
        StHdrLo,
        StHdrHi,
        StLoad,
        StFlush,
        StDone,
        StErr
    } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream, instruction-memory write and CPU-release signals of the program loader.
interface instr_loader_if #(
    parameter int unsigned ADDR_W = 11
);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              cpu_rst_n;
    logic              done;
    logic              error;

    // Byte source / system side.
    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_wren, mem_addr, mem_data, cpu_rst_n, done, error
    );

    // Loader side.
    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_wren, mem_addr, mem_data, cpu_rst_n, done, error
    );
endinterface

// File: rtl/byte_packer.sv
// 4-lane little-endian byte-to-word assembler; flags the byte that completes a word.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [31:0] asm_q, asm_d;
    logic [1:0]  idx_q, idx_d;

    // Merge the incoming byte into its lane; the completed word is visible in the same cycle.
    always_comb begin
        asm_d = asm_q;
        idx_d = idx_q;
        if (clear_i) begin
            asm_d = '0;
            idx_d = '0;
        end else if (byte_valid_i) begin
            asm_d[8*idx_q +: 8] = byte_i;
            idx_d               = idx_q + 2'd1;
        end
    end

    assign word_o       = asm_d;
    assign word_valid_o = byte_valid_i && !clear_i && (idx_q == 2'd3);

    // Assembly register and lane index.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q <= '0;
            idx_q <= '0;
        end else begin
            asm_q <= asm_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot-time program loader: byte stream in, 32-bit words out to instr_mem, CPU held in reset.
module instr_loader #(
    parameter int unsigned ADDR_W    = cpu_pkg::ADDR_W,
    parameter int unsigned MAX_WORDS = 2 ** ADDR_W
) (
    input logic           clk,
    input logic           rst,
    instr_loader_if.slave bus
);
    import cpu_pkg::*;

    localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

    loader_state_t     state_q, state_d;
    logic [7:0]        count_lo_q, count_lo_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_wren_q, mem_wren_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;

    logic        byte_ready;
    logic        accept;
    logic [15:0] n_full;
    logic        pk_clear;
    logic        pk_valid;
    logic [31:0] pk_word;
    logic        pk_word_valid;

    assign byte_ready = (state_q == StHdrLo) || (state_q == StHdrHi) || (state_q == StLoad);
    assign accept     = bus.byte_valid && byte_ready;
    assign n_full     = {bus.byte_in, count_lo_q};
    assign pk_valid   = accept && (state_q == StLoad);

    byte_packer u_byte_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_valid),
        .byte_i       (bus.byte_in),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid)
    );

    // Next-state, counters and registered write-port values.
    always_comb begin
        state_d    = state_q;
        count_lo_d = count_lo_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        mem_wren_d = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        pk_clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StHdrLo;
                    pk_clear = 1'b1;
                end
            end
            StHdrLo: begin
                if (accept) begin
                    count_lo_d = bus.byte_in;
                    state_d    = StHdrHi;
                end
            end
            StHdrHi: begin
                if (accept) begin
                    n_d = n_full;
                    if (n_full == 16'd0) begin
                        state_d = StDone;
                    end else if ({1'b0, n_full} > MaxWords) begin
                        state_d = StErr;
                    end else begin
                        state_d    = StLoad;
                        word_cnt_d = '0;
                        addr_d     = '0;
                        pk_clear   = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (pk_word_valid) begin
                    mem_wren_d = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = pk_word;
                    // Wraps to 0 after a full-size image; no write follows, so harmless.
                    addr_d     = addr_q + 1'b1;
                    word_cnt_d = word_cnt_q + 16'd1;
                    if (word_cnt_q == n_q - 16'd1) begin
                        state_d = StFlush;
                    end
                end
            end
            // One idle cycle so the last write lands before the CPU is released.
            StFlush: state_d = StDone;
            StDone:  state_d = StDone;
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_lo_q <= '0;
            n_q        <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            mem_wren_q <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_lo_q <= count_lo_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            mem_wren_q <= mem_wren_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.mem_wren   = mem_wren_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
    assign bus.cpu_rst_n  = (state_q == StDone);
    assign bus.done       = (state_q == StDone);
    assign bus.error      = (state_q == StErr);

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table of single-word images plus load sequences.
module tb_instr_loader;
    import cpu_pkg::*;

    localparam int unsigned AW   = 11;
    localparam int unsigned MAXW = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_loader_if #(.ADDR_W(AW)) bus ();

    instr_loader #(.ADDR_W(AW), .MAX_WORDS(MAXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];
    logic [AW-1:0] max_addr;
    logic [31:0]   img[MAXW];

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    // Record every write seen on the memory port.
    always @(negedge clk) begin
        if (bus.mem_wren) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_data);
            if (bus.mem_addr > max_addr) max_addr = bus.mem_addr;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        max_addr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Offer one byte and return just after the edge that accepts it; stalls = cycles waited.
    task automatic send_byte(input logic [7:0] b, output int stalls);
        int n;
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        n = 0;
        while (!bus.byte_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            errors++;
            checks++;
            $display("FAIL send_byte_timeout: byte %0h not accepted within 50 cycles", b);
        end else begin
            @(posedge clk);
        end
        stalls = n;
    endtask

    task automatic gap();
        @(negedge clk);
        bus.byte_valid = 1'b0;
        @(posedge clk);
    endtask

    // Header then payload from img[]; payload stalls are summed into stalls.
    task automatic load_image(input int n, input bit gaps, output int stalls);
        logic [15:0] hb;
        int s;
        hb = 16'(n);
        stalls = 0;
        for (int i = 0; i < int'(HDR_BYTES); i++) send_byte(hb[8*i +: 8], s);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(img[w][8*k +: 8], s);
                stalls += s;
                if (gaps && !(w == n - 1 && k == 3)) gap();
            end
        end
    endtask

    initial begin
        int s;
        int bad;
        int ready_seen;

        vecs[0] = '{b0: 8'h78, b1: 8'h56, b2: 8'h34, b3: 8'h12, exp: 32'h1234_5678};
        vecs[1] = '{b0: 8'hEF, b1: 8'hBE, b2: 8'hAD, b3: 8'hDE, exp: 32'hDEAD_BEEF};
        vecs[2] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h80, exp: 32'h8000_0000};
        vecs[3] = '{b0: 8'h01, b1: 8'h02, b2: 8'h03, b3: 8'h04, exp: 32'h0403_0201};
        vecs[4] = '{b0: 8'hFF, b1: 8'h00, b2: 8'hFF, b3: 8'h00, exp: 32'h00FF_00FF};

        bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
        max_addr = '0;

        // Reset state.
        do_reset();
        @(negedge clk);
        check("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
        check("rst_mem_wren", 64'(bus.mem_wren), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_data", 64'(bus.mem_data), 64'd0);
        check("rst_cpu_rst_n", 64'(bus.cpu_rst_n), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_error", 64'(bus.error), 64'd0);

        // start together with a valid byte in IDLE: the byte must not be taken.
        bus.start = 1'b1; bus.byte_valid = 1'b1; bus.byte_in = 8'hAA;
        #1 check("idle_not_ready", 64'(bus.byte_ready), 64'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.byte_valid = 1'b0;

        // Table: one-word images.
        for (int v = 0; v < 5; v++) begin
            if (v != 0) begin
                do_reset();
                pulse_start();
            end
            send_byte(8'h01, s); send_byte(8'h00, s);
            send_byte(vecs[v].b0, s); send_byte(vecs[v].b1, s);
            send_byte(vecs[v].b2, s); send_byte(vecs[v].b3, s);
            @(negedge clk); bus.byte_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_nwrites", v), 64'(wa.size()), 64'd1);
            if (wa.size() == 1) begin
                check($sformatf("vec%0d_addr", v), 64'(wa[0]), 64'd0);
                check($sformatf("vec%0d_data", v), 64'(wd[0]), 64'(vecs[v].exp));
            end
            check($sformatf("vec%0d_done", v), 64'(bus.done), 64'd1);
        end

        // Two words, valid held high; done and cpu_rst_n rise 2 cycles after the last byte.
        img[0] = 32'h1234_5678; img[1] = 32'hDEAD_BEEF;
        do_reset(); pulse_start();
        load_image(2, 1'b0, s);
        @(negedge clk); bus.byte_valid = 1'b0;
        check("a_wren_t1", 64'(bus.mem_wren), 64'd1);
        check("a_done_t1", 64'(bus.done), 64'd0);
        check("a_cpu_rst_n_t1", 64'(bus.cpu_rst_n), 64'd0);
        @(negedge clk);
        check("a_done_t2", 64'(bus.done), 64'd1);
        check("a_cpu_rst_n_t2", 64'(bus.cpu_rst_n), 64'd1);
        check("a_wren_t2", 64'(bus.mem_wren), 64'd0);
        check("a_nwrites", 64'(wa.size()), 64'd2);
        if (wa.size() == 2) begin
            check("a_w0", {32'(wa[0]), wd[0]}, {32'd0, 32'h1234_5678});
            check("a_w1", {32'(wa[1]), wd[1]}, {32'd1, 32'hDEAD_BEEF});
        end
        pulse_start();
        repeat (3) @(negedge clk);
        check("a_done_ignores_start", {63'd0, bus.done}, 64'd1);
        check("a_no_extra_writes", 64'(wa.size()), 64'd2);

        // Same image with valid toggling: identical writes, no stalls in LOAD.
        do_reset(); pulse_start();
        load_image(2, 1'b1, s);
        @(negedge clk); bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("b_stalls", 64'(s), 64'd0);
        check("b_nwrites", 64'(wa.size()), 64'd2);
        if (wa.size() == 2) begin
            check("b_w0", {32'(wa[0]), wd[0]}, {32'd0, 32'h1234_5678});
            check("b_w1", {32'(wa[1]), wd[1]}, {32'd1, 32'hDEAD_BEEF});
        end
        check("b_done", 64'(bus.done), 64'd1);

        // Empty image.
        do_reset(); pulse_start();
        send_byte(8'h00, s); send_byte(8'h00, s);
        @(negedge clk); bus.byte_valid = 1'b0;
        check("c_done", 64'(bus.done), 64'd1);
        check("c_cpu_rst_n", 64'(bus.cpu_rst_n), 64'd1);
        repeat (3) @(negedge clk);
        check("c_nwrites", 64'(wa.size()), 64'd0);

        // Oversize header N=2049.
        do_reset(); pulse_start();
        send_byte(8'h01, s); send_byte(8'h08, s);
        @(negedge clk);
        check("d_error", 64'(bus.error), 64'd1);
        check("d_cpu_rst_n", 64'(bus.cpu_rst_n), 64'd0);
        ready_seen = 0;
        bus.byte_valid = 1'b1; bus.byte_in = 8'h55;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.byte_ready || bus.done || bus.cpu_rst_n || !bus.error) ready_seen++;
        end
        bus.byte_valid = 1'b0;
        check("d_stays_err", 64'(ready_seen), 64'd0);
        check("d_nwrites", 64'(wa.size()), 64'd0);

        // Reset after 5 payload bytes of a 3-word image, then a full reload.
        do_reset(); pulse_start();
        send_byte(8'h03, s); send_byte(8'h00, s);
        send_byte(8'h11, s); send_byte(8'h22, s); send_byte(8'h33, s);
        send_byte(8'h44, s); send_byte(8'h55, s);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("e_partial_write", {32'(wa.size()), (wd.size() > 0) ? wd[0] : 32'h0},
              {32'd1, 32'h4433_2211});
        check("e_rst_outputs",
              {bus.byte_ready, bus.mem_wren, 32'(bus.mem_addr), bus.mem_data, bus.cpu_rst_n,
               bus.done, bus.error}, 64'd0);
        clear_log();
        img[0] = 32'hA0A1_A2A3; img[1] = 32'hB0B1_B2B3; img[2] = 32'hC0C1_C2C3;
        pulse_start();
        load_image(3, 1'b0, s);
        @(negedge clk); bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("e_nwrites", 64'(wa.size()), 64'd3);
        if (wa.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("e_w%0d", i), {32'(wa[i]), wd[i]}, {32'(i), img[i]});
            end
        end
        check("e_done", 64'(bus.done), 64'd1);

        // Full-size image N=2048.
        for (int i = 0; i < int'(MAXW); i++) img[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0001;
        do_reset(); pulse_start();
        load_image(int'(MAXW), 1'b0, s);
        @(negedge clk); bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("f_nwrites", 64'(wa.size()), 64'(MAXW));
        bad = 0;
        for (int i = 0; i < wa.size(); i++) begin
            if (wa[i] !== AW'(i) || wd[i] !== img[i]) begin
                if (bad == 0) $display("FAIL f_write[%0d]: got addr %0d data %0h expected addr %0d data %0h",
                                       i, wa[i], wd[i], i, img[i]);
                bad++;
            end
        end
        check("f_bad_writes", 64'(bad), 64'd0);
        if (wa.size() > 0) check("f_last_addr", 64'(wa[wa.size()-1]), 64'd2047);
        check("f_max_addr", 64'(max_addr), 64'd2047);
        check("f_done", 64'(bus.done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
